game_core: RTL and testbench

Parametrised game controller for the timed target-hit game; successor to the fixed 1 Hz timer, random-position, and display-counter logic at the top level. It owns the game state machine, countdown, target generator and score, all clocked from the single board clock with an internal tick prescaler. Registered BCD outputs drive the seven-segment decoders directly, and `position`/`pos_valid` feed the VGA renderer.

---
 rtl/game_core.sv | 191 +++++++++++++++++++
 tb/tb_game_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_core.sv
// game_core: timed target-hit game controller (state machine, BCD countdown, LFSR target, BCD score).
// Optional miss penalty: define GAME_MISS_PENALTY_EN.
module game_core #(
  parameter int N_POS    = 9,
  parameter int GAME_SEC = 30,
  parameter int MOVE_SEC = 1,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit_valid,
  input  logic [3:0] hit_pos,
  output logic [3:0] position,
  output logic       pos_valid,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [1:0] state,
  output logic       game_over
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int MOVE_W  = $clog2(MOVE_SEC + 1);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [MOVE_W-1:0]  MOVE_LAST = MOVE_W'(MOVE_SEC - 1);
  localparam logic [7:0] SEC_INIT  = {4'(GAME_SEC / 10), 4'(GAME_SEC % 10)};
  localparam logic [7:0] N_POS_8   = 8'(N_POS);
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  // Two-digit BCD helpers; both saturate at their end of range.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) r = v;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00) r = v;
    else if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  state_e               state_q, state_d;
  logic [3:0]           position_q, position_d;
  logic                 pos_valid_q, pos_valid_d;
  logic [7:0]           sec_q, sec_d;
  logic [7:0]           score_q, score_d;
  logic                 game_over_q, game_over_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [MOVE_W-1:0]    move_q, move_d;
  logic                 start_dly_q, start_dly_d;

  logic                 rise_s;
  logic                 tick_s;
  logic                 match_s;
  logic [7:0]           cand_s;
  logic [3:0]           reloc_s;

  // Relocation target: LFSR modulo N_POS, bumped by one if it would repeat the current target.
  always_comb begin
    cand_s = lfsr_q % N_POS_8;
    if (cand_s == {4'd0, position_q}) begin
      if (cand_s == N_POS_8 - 8'd1) reloc_s = 4'd0;
      else reloc_s = cand_s[3:0] + 4'd1;
    end else begin
      reloc_s = cand_s[3:0];
    end
  end

  // Next-state and datapath for the game FSM.
  always_comb begin
    state_d     = state_q;
    position_d  = position_q;
    sec_d       = sec_q;
    score_d     = score_q;
    game_over_d = 1'b0;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    presc_d     = presc_q;
    move_d      = move_q;
    start_dly_d = start;
    rise_s      = start & ~start_dly_q;
    tick_s      = 1'b0;
    match_s     = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (rise_s) begin
          state_d    = ST_PLAY;
          sec_d      = SEC_INIT;
          score_d    = 8'h00;
          presc_d    = {PRESC_W{1'b0}};
          move_d     = {MOVE_W{1'b0}};
          position_d = reloc_s;
        end else begin
          state_d = state_q;
        end
      end
      ST_PLAY: begin
        tick_s  = (presc_q == PRESC_MAX);
        match_s = hit_valid && (hit_pos == position_q);
        if (tick_s) presc_d = {PRESC_W{1'b0}};
        else presc_d = presc_q + PRESC_W'(1);
        if (match_s) begin
          score_d = bcd_inc_sat(score_q);
        end else if (hit_valid) begin
`ifdef GAME_MISS_PENALTY_EN
          score_d = bcd_dec_sat(score_q);
`else
          score_d = score_q;
`endif
        end else begin
          score_d = score_q;
        end
        if (tick_s) begin
          sec_d = bcd_dec_sat(sec_q);
          if (sec_q == 8'h01) begin
            state_d     = ST_OVER;
            game_over_d = 1'b1;
          end else begin
            state_d = ST_PLAY;
          end
        end else begin
          sec_d = sec_q;
        end
        // A match hit owns the relocation even when a move tick lands on the same cycle.
        if (match_s) begin
          position_d = reloc_s;
          move_d     = {MOVE_W{1'b0}};
        end else if (tick_s && (move_q == MOVE_LAST)) begin
          position_d = reloc_s;
          move_d     = {MOVE_W{1'b0}};
        end else if (tick_s) begin
          move_d = move_q + MOVE_W'(1);
        end else begin
          move_d = move_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pos_valid_d = (state_d == ST_PLAY);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      position_q  <= 4'd0;
      pos_valid_q <= 1'b0;
      sec_q       <= SEC_INIT;
      score_q     <= 8'h00;
      game_over_q <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      presc_q     <= {PRESC_W{1'b0}};
      move_q      <= {MOVE_W{1'b0}};
      start_dly_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      position_q  <= position_d;
      pos_valid_q <= pos_valid_d;
      sec_q       <= sec_d;
      score_q     <= score_d;
      game_over_q <= game_over_d;
      lfsr_q      <= lfsr_d;
      presc_q     <= presc_d;
      move_q      <= move_d;
      start_dly_q <= start_dly_d;
    end
  end

  assign position   = position_q;
  assign pos_valid  = pos_valid_q;
  assign sec_tens   = sec_q[7:4];
  assign sec_ones   = sec_q[3:0];
  assign score_tens = score_q[7:4];
  assign score_ones = score_q[3:0];
  assign state      = state_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_core.sv
// Self-checking bench for game_core: small game (3 s, 4-cycle ticks) plus a 99 s instance for score saturation.
`timescale 1ns/1ps
module tb_game_core;

  localparam int NP = 9;
  localparam int GS = 3;
  localparam int MS = 2;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst, start, hit_valid;
  logic [3:0] hit_pos;
  logic [3:0] position, sec_tens, sec_ones, score_tens, score_ones;
  logic       pos_valid, game_over;
  logic [1:0] state;

  logic       start2, hit_valid2;
  logic [3:0] hit_pos2;
  logic [3:0] position2, sec_tens2, sec_ones2, score_tens2, score_ones2;
  logic       pos_valid2, game_over2;
  logic [1:0] state2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  game_core #(.N_POS(NP), .GAME_SEC(GS), .MOVE_SEC(MS), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .hit_valid(hit_valid), .hit_pos(hit_pos),
    .position(position), .pos_valid(pos_valid), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .score_tens(score_tens), .score_ones(score_ones), .state(state), .game_over(game_over));

  game_core #(.N_POS(NP), .GAME_SEC(99), .MOVE_SEC(MS), .TICK_DIV(TD)) dut99 (
    .clk(clk), .rst(rst), .start(start2), .hit_valid(hit_valid2), .hit_pos(hit_pos2),
    .position(position2), .pos_valid(pos_valid2), .sec_tens(sec_tens2), .sec_ones(sec_ones2),
    .score_tens(score_tens2), .score_ones(score_ones2), .state(state2), .game_over(game_over2));

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int miss_adj(input int s);
`ifdef GAME_MISS_PENALTY_EN
    return (s > 0) ? s - 1 : 0;
`else
    return s;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT one step after the PLAY-entry edge (k = 0).
  task automatic begin_game(output logic [3:0] pos_before);
    start = 1'b0;
    step();
    pos_before = position;
    start = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; hit_valid = 1'b0; hit_pos = 4'd0;
    start2 = 1'b0; hit_valid2 = 1'b0; hit_pos2 = 4'd0;
    repeat (3) step();
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%0h exp=0", state); end
    checks++; if ({sec_tens, sec_ones} !== bcd(GS)) begin failures++; $display("FAIL reset_sec got=%0h exp=%0h", {sec_tens, sec_ones}, bcd(GS)); end
    checks++; if ({score_tens, score_ones} !== 8'h00) begin failures++; $display("FAIL reset_score got=%0h exp=0", {score_tens, score_ones}); end
    checks++; if (pos_valid !== 1'b0 || game_over !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", pos_valid, game_over); end
    checks++; if (position !== 4'd0) begin failures++; $display("FAIL reset_position got=%0d exp=0", position); end
    rst = 1'b1;
    hit_valid = 1'b1; hit_pos = 4'd0;
    step();
    hit_valid = 1'b0;
    checks++; if (state !== 2'b00 || {score_tens, score_ones} !== 8'h00) begin failures++; $display("FAIL idle_hit got=%0h/%0h exp=0/0", state, {score_tens, score_ones}); end
  endtask

  task automatic test_full_game();
    int rem;
    start = 1'b1;
    step();
    checks++; if (state !== 2'b01 || pos_valid !== 1'b1) begin failures++; $display("FAIL play_entry got=%0h/%b exp=1/1", state, pos_valid); end
    for (int k = 1; k <= 14; k++) begin
      step();
      rem = (k >= GS * TD) ? 0 : GS - k / TD;
      checks++; if ({sec_tens, sec_ones} !== bcd(rem)) begin failures++; $display("FAIL sec_k%0d got=%0h exp=%0h", k, {sec_tens, sec_ones}, bcd(rem)); end
      checks++; if (state !== ((k >= GS * TD) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL state_k%0d got=%0h", k, state); end
      checks++; if (game_over !== (k == GS * TD)) begin failures++; $display("FAIL game_over_k%0d got=%b exp=%b", k, game_over, (k == GS * TD)); end
      checks++; if (pos_valid !== (k < GS * TD)) begin failures++; $display("FAIL pos_valid_k%0d got=%b", k, pos_valid); end
    end
  endtask

  task automatic test_target_move();
    logic [3:0] prev;
    begin_game(prev);
    checks++; if (position === prev || position >= NP) begin failures++; $display("FAIL entry_reloc got=%0d prev=%0d", position, prev); end
    for (int k = 1; k <= 14; k++) begin
      prev = position;
      step();
      checks++;
      if ((k == TD * MS) ? (position === prev) : (position !== prev)) begin
        failures++; $display("FAIL move_k%0d got=%0d prev=%0d change_exp=%b", k, position, prev, (k == TD * MS));
      end
      checks++; if (position >= NP) begin failures++; $display("FAIL move_range got=%0d exp<%0d", position, NP); end
    end
  endtask

  task automatic test_hits();
    logic [3:0] prev;
    int sm, ticks, kind;
    bit chg;
    begin_game(prev);
    sm = 0; ticks = 0;
    for (int k = 0; k <= 12; k++) begin
      // k 0..2 directed matches, k 3 directed miss at 12, then random, k 12 is in OVER
      kind = (k < 3) ? 1 : (k == 3) ? 3 : (k == 12) ? 1 : int'($urandom_range(0, 2));
      hit_valid = (kind != 0);
      if (kind == 1) hit_pos = position;
      else if (kind == 3) hit_pos = 4'd12;
      else begin
        hit_pos = 4'($urandom_range(0, 15));
        if (hit_pos == position) hit_pos = hit_pos + 4'd1;
      end
      prev = position;
      chg = 1'b0;
      if (k < GS * TD) begin
        if (kind == 1) begin
          sm = (sm < 99) ? sm + 1 : 99; chg = 1'b1; ticks = 0;
        end else if (kind != 0) begin
          sm = miss_adj(sm);
        end
        if ((k + 1) % TD == 0 && kind != 1) begin
          ticks++;
          if (ticks == MS) begin chg = 1'b1; ticks = 0; end
        end
      end
      step();
      hit_valid = 1'b0;
      checks++; if ({score_tens, score_ones} !== bcd(sm)) begin failures++; $display("FAIL score_k%0d kind%0d got=%0h exp=%0h", k + 1, kind, {score_tens, score_ones}, bcd(sm)); end
      if (k + 1 != GS * TD) begin
        checks++;
        if (chg ? (position === prev) : (position !== prev)) begin
          failures++; $display("FAIL hit_pos_k%0d got=%0d prev=%0d change_exp=%b", k + 1, position, prev, chg);
        end
      end
    end
  endtask

  task automatic test_final_tick_hit();
    logic [3:0] prev;
    begin_game(prev);
    repeat (GS * TD - 1) step();
    hit_valid = 1'b1; hit_pos = position;
    step();
    hit_valid = 1'b0;
    checks++; if ({score_tens, score_ones} !== 8'h01) begin failures++; $display("FAIL final_hit_score got=%0h exp=01", {score_tens, score_ones}); end
    checks++; if (state !== 2'b10 || game_over !== 1'b1) begin failures++; $display("FAIL final_hit_state got=%0h/%b exp=2/1", state, game_over); end
    checks++; if ({sec_tens, sec_ones} !== 8'h00) begin failures++; $display("FAIL final_hit_sec got=%0h exp=00", {sec_tens, sec_ones}); end
  endtask

  task automatic test_restart();
    logic [3:0] prev;
    begin_game(prev);
    checks++; if (state !== 2'b01 || {score_tens, score_ones} !== 8'h00 || {sec_tens, sec_ones} !== bcd(GS)) begin
      failures++; $display("FAIL restart got=%0h/%0h/%0h exp=1/00/%0h", state, {score_tens, score_ones}, {sec_tens, sec_ones}, bcd(GS));
    end
    hit_valid = 1'b1; hit_pos = position;
    step();
    hit_valid = 1'b0;
    repeat (4) step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    checks++; if (state !== 2'b01 || {sec_tens, sec_ones} !== bcd(GS - 7 / TD) || {score_tens, score_ones} !== 8'h01) begin
      failures++; $display("FAIL midgame_start got=%0h/%0h/%0h exp=1/%0h/01", state, {sec_tens, sec_ones}, {score_tens, score_ones}, bcd(GS - 7 / TD));
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    #2;
    checks++; if (state !== 2'b00 || pos_valid !== 1'b0 || game_over !== 1'b0 || position !== 4'd0) begin
      failures++; $display("FAIL async_reset got=%0h/%b/%b/%0d exp=0/0/0/0", state, pos_valid, game_over, position);
    end
    checks++; if ({sec_tens, sec_ones} !== bcd(GS) || {score_tens, score_ones} !== 8'h00) begin
      failures++; $display("FAIL async_reset_digits got=%0h/%0h exp=%0h/00", {sec_tens, sec_ones}, {score_tens, score_ones}, bcd(GS));
    end
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_saturate();
    int hits;
    bit h;
    start2 = 1'b1;
    step();
    checks++; if ({sec_tens2, sec_ones2} !== 8'h99 || pos_valid2 !== 1'b1 || game_over2 !== 1'b0) begin
      failures++; $display("FAIL sat_entry got=%0h/%b/%b exp=99/1/0", {sec_tens2, sec_ones2}, pos_valid2, game_over2);
    end
    hits = 0;
    for (int c = 0; c < 350 && hits < 100; c++) begin
      h = ($urandom_range(0, 3) != 0);
      hit_valid2 = h; hit_pos2 = position2;
      step();
      hit_valid2 = 1'b0;
      if (h) hits++;
      checks++; if ({score_tens2, score_ones2} !== bcd((hits < 99) ? hits : 99)) begin
        failures++; $display("FAIL sat_score hits=%0d got=%0h exp=%0h", hits, {score_tens2, score_ones2}, bcd((hits < 99) ? hits : 99));
      end
    end
    checks++; if (hits != 100) begin failures++; $display("FAIL sat_budget got=%0d exp=100", hits); end
    checks++; if ({score_tens2, score_ones2} !== 8'h99 || state2 !== 2'b01) begin
      failures++; $display("FAIL sat_final got=%0h/%0h exp=99/1", {score_tens2, score_ones2}, state2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_game();
    test_target_move();
    test_hits();
    test_final_tick_hit();
    test_restart();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
